decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Buffered, parametrised instruction decoder between instruction fetch and the register file/ALU/control.
//  Accepts 32-bit instructions over a valid/ready handshake and decodes each one when it is pushed.
//  Queues up to DEPTH decoded entries and presents the head entry's fields to the execute side.
//  Adds stall tolerance, pipeline flush, sign-extended branch offset and illegal-opcode detection.
// PARAMETERS
//  REG_ADDR_W   3    register address width (1..8); low bits of each register byte field
//  NUM_OPCODES  12   opcodes 0..NUM_OPCODES-1 are legal; >= NUM_OPCODES flags ILLEGAL
//  DEPTH        2    queue entries; power of two, >= 2
//  OFFSET_W     32   BRANCH_OFFSET width; must be >= 10
// PORTS
//  CLK            in   1               clock, all state changes on rising edge
//  RESET          in   1               synchronous reset, active-high
//  FLUSH          in   1               synchronous queue clear (taken branch/jump)
//  IN_VALID       in   1               INSTRUCTION is valid this cycle
//  IN_READY       out  1               queue can accept an instruction this cycle
//  INSTRUCTION    in   32              raw instruction word
//  OUT_VALID      out  1               head entry is valid
//  OUT_READY      in   1               consumer takes the head entry this cycle
//  OPCODE         out  8               head INSTRUCTION[31:24]
//  READREG1       out  REG_ADDR_W      head INSTRUCTION[16 +: REG_ADDR_W]
//  READREG2       out  REG_ADDR_W      head INSTRUCTION[0 +: REG_ADDR_W]
//  WRITEREG       out  REG_ADDR_W      head INSTRUCTION[8 +: REG_ADDR_W]
//  IMMEDIATE      out  8               head INSTRUCTION[7:0]
//  BRANCH_OFFSET  out  OFFSET_W        sign-extended INSTRUCTION[23:16], shifted left by 2 (byte offset)
//  ILLEGAL        out  1               OUT_VALID && OPCODE >= NUM_OPCODES
//  COUNT          out  $clog2(DEPTH)+1 current number of queued entries
// BEHAVIOUR
//  - Decoding happens at push time. Each entry stores the decoded fields plus the illegal bit.
//  - Outputs are read combinationally from the head storage, so no decode logic sits on the output path.
//  - push = IN_VALID && IN_READY; pop = OUT_VALID && OUT_READY.
//  - IN_READY = (COUNT != DEPTH), a function of registered state only.
//  - OUT_VALID = (COUNT != 0).
//  - Latency: an instruction pushed at edge N appears on the outputs in cycle N+1 if the queue was empty.
//  - Order is strict FIFO. Read/write pointers wrap modulo DEPTH.
//  - Simultaneous push and pop with 0 < COUNT < DEPTH: COUNT is unchanged and both pointers advance.
//  - Empty: pop is impossible, so a push alone takes COUNT 0 -> 1. There is no same-cycle bypass.
//  - Full: IN_READY = 0, so a pop alone takes COUNT DEPTH -> DEPTH-1.
//    IN_READY rises in the following cycle, not the same cycle.
//  - While OUT_VALID = 0, OPCODE/READREG*/WRITEREG/IMMEDIATE/BRANCH_OFFSET/ILLEGAL are forced to 0.
//  - An entry held while OUT_READY = 0 keeps all outputs stable until it is popped.
//  - FLUSH: at the edge, COUNT = 0 and both pointers = 0.
//    A push or pop requested in that same cycle is discarded and has no effect.
//  - RESET: same effect as FLUSH and takes priority over everything.
//    It may be applied mid-operation; queued entries are lost.
//    After reset: IN_READY = 1, OUT_VALID = 0, COUNT = 0, all field outputs = 0.
//  - ILLEGAL entries are queued and delivered like any other entry.
//    Control decides the trap; this block never drops them.
//  - BRANCH_OFFSET arithmetic: {{(OFFSET_W-10){b[7]}}, b[7:0], 2'b00} with b = INSTRUCTION[23:16].
// TESTING
//  1. Reset, push 32'h02_01_03_04 with OUT_READY=0 -> next cycle: OUT_VALID=1, OPCODE=02, READREG1=1,
//     WRITEREG=3, READREG2=4, IMMEDIATE=04, COUNT=1, and these values are held while OUT_READY=0.
//  2. DEPTH=2: push A, B with OUT_READY=0 -> COUNT=2, IN_READY=0, a third push is ignored.
//     Then pop -> A, then B, in order.
//  3. COUNT=1, push C while popping head in the same cycle -> COUNT stays 1, head becomes C next cycle.
//  4. Instruction 32'h08_FE_00_00 -> BRANCH_OFFSET = -8 (32'hFFFFFFF8).
//     Instruction 32'h08_7F_00_00 -> BRANCH_OFFSET = 32'h000001FC.
//  5. NUM_OPCODES=12: opcode 8'h0B -> ILLEGAL=0; opcode 8'h0C -> ILLEGAL=1 and the entry is still delivered.
//  6. COUNT=2, assert FLUSH with IN_VALID=1 -> next cycle COUNT=0, OUT_VALID=0, fields=0.
//     RESET asserted mid-stream -> same result, and IN_READY=1.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction decode queue: decodes each 32-bit word as it is accepted, buffers up to
// DEPTH decoded entries in FIFO order, and presents the head entry to the execute side.
module decode_queue #(
    parameter int REG_ADDR_W  = 3,
    parameter int NUM_OPCODES = 12,
    parameter int DEPTH       = 2,
    parameter int OFFSET_W    = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [31:0]             INSTRUCTION,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [7:0]              OPCODE,
    output logic [REG_ADDR_W-1:0]   READREG1,
    output logic [REG_ADDR_W-1:0]   READREG2,
    output logic [REG_ADDR_W-1:0]   WRITEREG,
    output logic [7:0]              IMMEDIATE,
    output logic [OFFSET_W-1:0]     BRANCH_OFFSET,
    output logic                    ILLEGAL,
    output logic [$clog2(DEPTH):0]  COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0] NUM_OPC = 9'(NUM_OPCODES);

    typedef struct packed {
        logic [7:0]            opcode;
        logic [REG_ADDR_W-1:0] readreg1;
        logic [REG_ADDR_W-1:0] readreg2;
        logic [REG_ADDR_W-1:0] writereg;
        logic [7:0]            immediate;
        logic [OFFSET_W-1:0]   branch_offset;
        logic                  illegal;
    } entry_t;

    // Decode is done on the write side so the head outputs are pure storage reads.
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t e;
        e.opcode        = instr[31:24];
        e.readreg1      = instr[16 +: REG_ADDR_W];
        e.readreg2      = instr[0 +: REG_ADDR_W];
        e.writereg      = instr[8 +: REG_ADDR_W];
        e.immediate     = instr[7:0];
        e.branch_offset = {{(OFFSET_W-10){instr[23]}}, instr[23:16], 2'b00};
        e.illegal       = ({1'b0, instr[31:24]} >= NUM_OPC);
        return e;
    endfunction

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    entry_t          head;
    logic            unused_instr_bits;

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // ready depends only on registered state, never on the partner's valid.
    assign IN_READY  = (count != CW'(DEPTH));
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;
    assign COUNT     = count;
    assign head      = mem[rd_ptr];
    assign unused_instr_bits = ^INSTRUCTION;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Flush and reset share the same clearing path; reset wins simply by also clearing.
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && !FLUSH && push) mem[wr_ptr] <= decode(INSTRUCTION);
    end

    always_comb begin
        OPCODE        = '0;
        READREG1      = '0;
        READREG2      = '0;
        WRITEREG      = '0;
        IMMEDIATE     = '0;
        BRANCH_OFFSET = '0;
        ILLEGAL       = 1'b0;
        if (OUT_VALID) begin
            OPCODE        = head.opcode;
            READREG1      = head.readreg1;
            READREG2      = head.readreg2;
            WRITEREG      = head.writereg;
            IMMEDIATE     = head.immediate;
            BRANCH_OFFSET = head.branch_offset;
            ILLEGAL       = head.illegal;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenario tasks plus a randomized run against a
// queue-based reference model that decodes fields arithmetically.
module tb_decode_queue;

    localparam int RW   = 3;
    localparam int NOPC = 12;
    localparam int DEP  = 2;
    localparam int OW   = 32;
    localparam int HW   = 1 + 8 + 3*RW + 8 + OW + 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    opcode;
    logic [RW-1:0] readreg1;
    logic [RW-1:0] readreg2;
    logic [RW-1:0] writereg;
    logic [7:0]    immediate;
    logic [OW-1:0] branch_offset;
    logic          illegal;
    logic [1:0]    count;
    logic [HW-1:0] got_head;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    decode_queue #(.REG_ADDR_W(RW), .NUM_OPCODES(NOPC), .DEPTH(DEP), .OFFSET_W(OW)) dut (
        .CLK(clk), .RESET(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .INSTRUCTION(instruction),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OPCODE(opcode), .READREG1(readreg1), .READREG2(readreg2), .WRITEREG(writereg),
        .IMMEDIATE(immediate), .BRANCH_OFFSET(branch_offset), .ILLEGAL(illegal), .COUNT(count)
    );

    assign got_head = {out_valid, opcode, readreg1, readreg2, writereg, immediate, branch_offset, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected head outputs for a word, from the field rules with plain arithmetic.
    function automatic logic [HW-1:0] exp_head(input bit v, input logic [31:0] w);
        int op;
        int b;
        logic [OW-1:0] o;
        if (!v) return '0;
        op = int'(w >> 24);
        b  = int'((w >> 16) & 32'hFF);
        if (b > 127) b = b - 256;
        o = OW'(b * 4);
        return {1'b1, 8'(op), RW'((w >> 16) % (1 << RW)), RW'(w % (1 << RW)),
                RW'((w >> 8) % (1 << RW)), 8'(w % 256), o, (op >= NOPC)};
    endfunction

    task automatic tick(input logic v, input logic [31:0] w, input logic ordy,
                        input logic fl, input logic r);
        in_valid = v; instruction = w; out_ready = ordy; flush = fl; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(0, 32'h0, 0, 0, 1);
        tick(0, 32'h0, 0, 0, 1);
        in_valid = 0; rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (got_head !== exp_head(0, 32'h0)) begin n_err++; $display("FAIL reset_head got %h want 0", got_head); end
    endtask

    task automatic test_hold();
        logic [31:0] w = 32'h02_01_03_04;
        do_reset();
        tick(1, w, 0, 0, 0);
        n_cmp++; if ({out_valid, opcode, readreg1, writereg, readreg2, immediate} !== {1'b1, 8'h02, 3'd1, 3'd3, 3'd4, 8'h04})
            begin n_err++; $display("FAIL hold_fields got %h want 1_02_1_3_4_04", {out_valid, opcode, readreg1, writereg, readreg2, immediate}); end
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL hold_count got %0d want 1", count); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 32'hFFFF_FFFF, 0, 0, 0);
            n_cmp++; if (got_head !== exp_head(1, w)) begin n_err++; $display("FAIL hold_stable got %h want %h", got_head, exp_head(1, w)); end
        end
    endtask

    task automatic test_fill_order();
        logic [31:0] a = 32'h01_12_05_33;
        logic [31:0] b = 32'h03_80_06_44;
        do_reset();
        tick(1, a, 0, 0, 0);
        tick(1, b, 0, 0, 0);
        n_cmp++; if ({count, in_ready} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL full_state got cnt=%0d rdy=%0b want cnt=2 rdy=0", count, in_ready); end
        tick(1, 32'h05_55_55_55, 0, 0, 0);
        n_cmp++; if (count !== 2'd2) begin n_err++; $display("FAIL full_ignore got %0d want 2", count); end
        n_cmp++; if (got_head !== exp_head(1, a)) begin n_err++; $display("FAIL order_a got %h want %h", got_head, exp_head(1, a)); end
        tick(0, 32'h0, 1, 0, 0);
        n_cmp++; if (got_head !== exp_head(1, b)) begin n_err++; $display("FAIL order_b got %h want %h", got_head, exp_head(1, b)); end
        n_cmp++; if ({count, in_ready} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL after_pop got cnt=%0d rdy=%0b want cnt=1 rdy=1", count, in_ready); end
        tick(0, 32'h0, 1, 0, 0);
        n_cmp++; if ({count, got_head} !== {2'd0, exp_head(0, 0)}) begin n_err++; $display("FAIL drained got cnt=%0d head=%h want 0", count, got_head); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h04_22_01_02;
        logic [31:0] c = 32'h06_33_07_05;
        do_reset();
        tick(1, a, 0, 0, 0);
        tick(1, c, 1, 0, 0);
        n_cmp++; if (count !== 2'd1) begin n_err++; $display("FAIL b2b_count got %0d want 1", count); end
        n_cmp++; if (got_head !== exp_head(1, c)) begin n_err++; $display("FAIL b2b_head got %h want %h", got_head, exp_head(1, c)); end
    endtask

    task automatic test_branch_offset();
        do_reset();
        tick(1, 32'h08_FE_00_00, 0, 0, 0);
        n_cmp++; if (branch_offset !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL boff_neg got %h want fffffff8", branch_offset); end
        tick(1, 32'h08_7F_00_00, 1, 0, 0);
        n_cmp++; if (branch_offset !== 32'h0000_01FC) begin n_err++; $display("FAIL boff_pos got %h want 000001fc", branch_offset); end
    endtask

    task automatic test_illegal();
        do_reset();
        tick(1, 32'h0B_01_02_03, 0, 0, 0);
        n_cmp++; if ({out_valid, illegal} !== 2'b10) begin n_err++; $display("FAIL illegal_0b got v=%0b ill=%0b want v=1 ill=0", out_valid, illegal); end
        tick(1, 32'h0C_01_02_03, 1, 0, 0);
        n_cmp++; if ({out_valid, opcode, illegal} !== {1'b1, 8'h0C, 1'b1}) begin n_err++; $display("FAIL illegal_0c got v=%0b op=%h ill=%0b want 1 0c 1", out_valid, opcode, illegal); end
        tick(0, 32'h0, 1, 0, 0);
        n_cmp++; if ({count, illegal} !== {2'd0, 1'b0}) begin n_err++; $display("FAIL illegal_popped got cnt=%0d ill=%0b want 0 0", count, illegal); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        tick(1, 32'h01_11_11_11, 0, 0, 0);
        tick(1, 32'h02_22_22_22, 0, 0, 0);
        tick(1, 32'h03_33_33_33, 1, 1, 0);
        n_cmp++; if ({count, got_head} !== {2'd0, exp_head(0, 0)}) begin n_err++; $display("FAIL flush got cnt=%0d head=%h want 0", count, got_head); end
        tick(1, 32'h01_11_11_11, 0, 0, 0);
        tick(1, 32'h02_22_22_22, 0, 0, 0);
        tick(1, 32'h03_33_33_33, 1, 0, 1);
        n_cmp++; if ({count, in_ready, got_head} !== {2'd0, 1'b1, exp_head(0, 0)}) begin n_err++; $display("FAIL mid_reset got cnt=%0d rdy=%0b head=%h want 0 1 0", count, in_ready, got_head); end
        rst = 0;
    endtask

    task automatic test_random();
        logic        iv, ordy, fl, do_push, do_pop;
        logic [31:0] w;
        int          sz;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            w    = {8'($urandom_range(0, 15)), 24'($urandom)};
            sz      = exp_q.size();
            do_push = iv && (sz < DEP);
            do_pop  = (sz > 0) && ordy;
            tick(iv, w, ordy, fl, 0);
            if (fl) exp_q.delete();
            else begin
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back(w);
            end
            sz = exp_q.size();
            n_cmp++; if (count !== 2'(sz)) begin n_err++; $display("FAIL rand_count cyc=%0d got %0d want %0d", i, count, sz); end
            n_cmp++; if (in_ready !== (sz < DEP)) begin n_err++; $display("FAIL rand_ready cyc=%0d got %0b want %0b", i, in_ready, sz < DEP); end
            n_cmp++; if (got_head !== exp_head(sz > 0, (sz > 0) ? exp_q[0] : 32'h0))
                begin n_err++; $display("FAIL rand_head cyc=%0d got %h want %h", i, got_head, exp_head(sz > 0, (sz > 0) ? exp_q[0] : 32'h0)); end
        end
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; instruction = '0; out_ready = 0;
        test_reset();
        test_hold();
        test_fill_order();
        test_back_to_back();
        test_branch_offset();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
